fifo_read_streamer: RTL and testbench



---
 rtl/fifo_read_streamer.sv | 57 +++++
 tb/tb_fifo_read_streamer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_streamer.sv
// fifo_read_streamer: async-FIFO read side re-presented as a valid/ready stream via a prefetch buffer; define FIFO_READ_STREAMER_CNT_EN to add rd_count
module fifo_read_streamer #(
  parameter int DATA_WIDTH = 32,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                             rclk,
  input  logic                             rrst_n,
  input  logic                             fifo_empty,
  input  logic [DATA_WIDTH-1:0]            fifo_dout,
  output logic                             fifo_ren,
  output logic                             m_valid,
  output logic [DATA_WIDTH-1:0]            m_data,
  input  logic                             m_ready,
  output logic [$clog2(BUF_DEPTH+1)-1:0]   buf_level
`ifdef FIFO_READ_STREAMER_CNT_EN
  ,
  output logic [31:0]                      rd_count
`endif
);
  localparam int LW = $clog2(BUF_DEPTH + 1);
  localparam int IW = $clog2(BUF_DEPTH);
  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [LW-1:0] occ;
  logic [LW:0] credit;
  logic [IW-1:0] wr_idx, rd_idx;
  logic inflight, pop;
  assign credit = {1'b0, occ} + {{LW{1'b0}}, inflight};
  assign fifo_ren = rrst_n & ~fifo_empty & (credit < (LW+1)'(BUF_DEPTH));
  assign m_valid = occ != '0;
  assign m_data = mem[rd_idx];
  assign pop = m_valid & m_ready;
  assign buf_level = occ;
  // indices, occupancy and the one-cycle read-in-flight flag
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      occ <= '0;
      inflight <= 1'b0;
      wr_idx <= '0;
      rd_idx <= '0;
    end else begin
      inflight <= fifo_ren;
      occ <= occ + LW'(inflight) - LW'(pop);
      if (inflight) wr_idx <= (wr_idx == IW'(BUF_DEPTH - 1)) ? '0 : wr_idx + IW'(1);
      if (pop) rd_idx <= (rd_idx == IW'(BUF_DEPTH - 1)) ? '0 : rd_idx + IW'(1);
    end
  end
  // capture the word returned for last cycle's read; a slot is always free
  always_ff @(posedge rclk) begin
    if (rrst_n && inflight) mem[wr_idx] <= fifo_dout;
  end
`ifdef FIFO_READ_STREAMER_CNT_EN
  // count accepted words, wrapping naturally at 2^32
  always_ff @(posedge rclk) begin
    rd_count <= !rrst_n ? '0 : rd_count + 32'(pop);
  end
`endif
endmodule

// File: tb/tb_fifo_read_streamer.sv
// tb_fifo_read_streamer: FIFO model plus in-order scoreboard checking the stream side of fifo_read_streamer
module tb_fifo_read_streamer;
  localparam int DW = 32;
  localparam int BD = 4;
  localparam int LW = $clog2(BD + 1);
  logic rclk = 1'b0;
  logic rrst_n = 1'b0;
  logic m_ready = 1'b0;
  logic [DW-1:0] fifo_dout = '0;
  logic fifo_empty, fifo_ren, m_valid;
  logic [DW-1:0] m_data;
  logic [LW-1:0] buf_level;
`ifdef FIFO_READ_STREAMER_CNT_EN
  logic [31:0] rd_count;
`endif
  logic [DW-1:0] fifo_mem [256];
  int unsigned wr_ptr = 0;
  int unsigned rd_ptr = 0;
  logic [DW-1:0] exp_q [$];
  int errors = 0;
  int checks = 0;

  fifo_read_streamer #(.DATA_WIDTH(DW), .BUF_DEPTH(BD)) dut (
    .rclk(rclk),
    .rrst_n(rrst_n),
    .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout),
    .fifo_ren(fifo_ren),
    .m_valid(m_valid),
    .m_data(m_data),
    .m_ready(m_ready),
    .buf_level(buf_level)
`ifdef FIFO_READ_STREAMER_CNT_EN
    ,
    .rd_count(rd_count)
`endif
  );

  always #5 rclk = ~rclk;

  assign fifo_empty = (rd_ptr == wr_ptr);

  // FIFO read side: data one cycle after ren; reset empties it like a pointer reset
  always @(posedge rclk) begin
    if (!rrst_n) rd_ptr <= wr_ptr;
    else if (fifo_ren && !fifo_empty) begin
      fifo_dout <= fifo_mem[rd_ptr % 256];
      rd_ptr <= rd_ptr + 1;
    end
  end

  task automatic push(input logic [DW-1:0] w);
    fifo_mem[wr_ptr % 256] = w;
    wr_ptr++;
    exp_q.push_back(w);
  endtask

  task automatic do_reset(input int n);
    @(negedge rclk);
    rrst_n = 1'b0;
    m_ready = 1'b0;
    repeat (n) @(negedge rclk);
    rrst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset;
    do_reset(2);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (fifo_ren !== 1'b0 || m_valid !== 1'b0 || buf_level !== '0) begin
        errors++;
        $display("FAIL idle c%0d: ren=%b valid=%b level=%0d, required 0 0 0", i, fifo_ren, m_valid, buf_level);
      end
      @(negedge rclk);
    end
  endtask

  task automatic test_stream;
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(DW'(32'hA0 + i));
    #1;
    checks++;
    if (fifo_ren !== 1'b1 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream c0: ren=%b valid=%b, required 1 0", fifo_ren, m_valid);
    end
    for (int c = 1; c <= 10; c++) begin
      @(negedge rclk);
      checks++;
      if (fifo_ren !== (c < 8)) begin
        errors++;
        $display("FAIL stream ren c%0d: got %b, required %b", c, fifo_ren, c < 8);
      end
      checks++;
      if (c >= 2 && c <= 9) begin
        if (m_valid !== 1'b1 || m_data !== exp_q[0]) begin
          errors++;
          $display("FAIL stream data c%0d: valid=%b data=%h, required 1 %h", c, m_valid, m_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end else if (m_valid !== 1'b0) begin
        errors++;
        $display("FAIL stream valid c%0d: got %b, required 0", c, m_valid);
      end
    end
  endtask

  task automatic test_backpressure;
    int reads = 0;
    int got = 0;
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) push(DW'(32'hC00 + i));
    #1;
    for (int c = 0; c < 12; c++) begin
      if (fifo_ren) reads++;
      if (m_valid) begin
        checks++;
        if (m_data !== exp_q[0]) begin
          errors++;
          $display("FAIL bp hold c%0d: data=%h, required %h", c, m_data, exp_q[0]);
        end
      end
      @(negedge rclk);
    end
    checks++;
    if (reads != BD || buf_level !== LW'(BD) || m_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp credit: reads=%0d level=%0d valid=%b, required %0d %0d 1", reads, buf_level, m_valid, BD, BD);
    end
    m_ready = 1'b1;
    for (int c = 0; c < 60 && got < 16; c++) begin
      if (m_valid) begin
        checks++;
        if (exp_q.size() == 0 || m_data !== exp_q[0]) begin
          errors++;
          $display("FAIL bp drain word %0d: data=%h, required %h", got, m_data, exp_q.size() ? exp_q[0] : '0);
        end
        if (exp_q.size()) void'(exp_q.pop_front());
        got++;
      end
      @(negedge rclk);
    end
    checks++;
    if (got != 16 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp count: delivered=%0d valid=%b, required 16 0", got, m_valid);
    end
  endtask

  task automatic test_toggle;
    int got = 0;
    logic held = 1'b0;
    logic [DW-1:0] held_data = '0;
    for (int i = 0; i < 6; i++) push(DW'(32'hD0 + i));
    for (int c = 0; c < 40; c++) begin
      m_ready = (c % 2 == 0);
      if (m_valid) begin
        if (held) begin
          checks++;
          if (m_data !== held_data) begin
            errors++;
            $display("FAIL toggle stable c%0d: data=%h, required %h", c, m_data, held_data);
          end
        end
        if (m_ready) begin
          checks++;
          if (exp_q.size() == 0 || m_data !== exp_q[0]) begin
            errors++;
            $display("FAIL toggle order c%0d: data=%h, required %h", c, m_data, exp_q.size() ? exp_q[0] : '0);
          end
          if (exp_q.size()) void'(exp_q.pop_front());
          got++;
        end
      end
      held = m_valid & ~m_ready;
      held_data = m_data;
      @(negedge rclk);
    end
    checks++;
    if (got != 6) begin
      errors++;
      $display("FAIL toggle count: delivered=%0d, required 6", got);
    end
  endtask

  task automatic test_reset_mid;
    int c = 0;
    int got = 0;
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) push(DW'(32'hE0 + i));
    #1;
    while (buf_level !== LW'(2) && c < 20) begin
      @(negedge rclk);
      c++;
    end
    checks++;
    if (c != 3) begin
      errors++;
      $display("FAIL mid setup: occ=2 reached at c%0d, required c3", c);
    end
    rrst_n = 1'b0;
    #1;
    checks++;
    if (fifo_ren !== 1'b0) begin
      errors++;
      $display("FAIL mid ren in reset: got %b, required 0", fifo_ren);
    end
    @(negedge rclk);
    rrst_n = 1'b1;
    exp_q.delete();
    checks++;
    if (buf_level !== '0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid cleared: level=%0d valid=%b, required 0 0", buf_level, m_valid);
    end
    push(DW'(32'hB0));
    m_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (m_valid) begin
        checks++;
        if (got != 0 || m_data !== DW'(32'hB0)) begin
          errors++;
          $display("FAIL mid refill word %0d: data=%h, required only b0", got, m_data);
        end
        got++;
      end
      @(negedge rclk);
    end
    exp_q.delete();
    checks++;
    if (got != 1) begin
      errors++;
      $display("FAIL mid refill count: delivered=%0d, required 1", got);
    end
  endtask

  task automatic test_random;
    logic held = 1'b0;
    logic [DW-1:0] held_data = '0;
    for (int c = 0; c < 700; c++) begin
      if (c < 600 && (wr_ptr - rd_ptr) < 200 && $urandom_range(0, 2) != 0) push($urandom);
      m_ready = (c >= 600) || ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if ((fifo_ren && fifo_empty) || buf_level > LW'(BD) || m_valid !== (buf_level != '0)) begin
        errors++;
        $display("FAIL rand flags c%0d: ren=%b empty=%b level=%0d valid=%b", c, fifo_ren, fifo_empty, buf_level, m_valid);
      end
      if (m_valid && held) begin
        checks++;
        if (m_data !== held_data) begin
          errors++;
          $display("FAIL rand stable c%0d: data=%h, required %h", c, m_data, held_data);
        end
      end
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0 || m_data !== exp_q[0]) begin
          errors++;
          $display("FAIL rand order c%0d: data=%h, required %h", c, m_data, exp_q.size() ? exp_q[0] : '0);
        end
        if (exp_q.size()) void'(exp_q.pop_front());
      end
      held = m_valid & ~m_ready;
      held_data = m_data;
      @(negedge rclk);
    end
    checks++;
    if (exp_q.size() != 0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL rand drain: %0d words undelivered valid=%b, required 0 0", exp_q.size(), m_valid);
    end
  endtask

`ifdef FIFO_READ_STREAMER_CNT_EN
  task automatic test_count;
    do_reset(1);
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) push(DW'(32'hF0 + i));
    repeat (12) @(negedge rclk);
    exp_q.delete();
    checks++;
    if (rd_count !== 32'd5) begin
      errors++;
      $display("FAIL count: rd_count=%0d, required 5", rd_count);
    end
    do_reset(1);
    checks++;
    if (rd_count !== 32'd0) begin
      errors++;
      $display("FAIL count reset: rd_count=%0d, required 0", rd_count);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_stream;
    test_backpressure;
    test_toggle;
    test_reset_mid;
    test_random;
`ifdef FIFO_READ_STREAMER_CNT_EN
    test_count;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
